// File: rtl/aes_pkg.sv
// AES-128 key schedule constants, FSM encoding, S-box and xtime helper.
// Shared by key_expansion_seq, its interface and aes_sub_word.
package aes_pkg;

    localparam int NK = 4;
    localparam int NW = 44;
    localparam int NR = 10;

    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_expansion_seq_if.sv
// Request/result bundle of the key expander: start, key, busy, done, words
// (+ round_ready with KEYEXP_ROUND_READY_EN). master = requester, slave = expander.
interface key_expansion_seq_if;
    import aes_pkg::*;

    logic                 start;
    logic [0:127]         key;
    logic                 busy;
    logic                 done;
    logic [0:32*NW-1]     words;
`ifdef KEYEXP_ROUND_READY_EN
    logic [0:NR]          round_ready;
`endif

    modport master (
        output start, key,
`ifdef KEYEXP_ROUND_READY_EN
        input  round_ready,
`endif
        input  busy, done, words
    );

    modport slave (
        input  start, key,
`ifdef KEYEXP_ROUND_READY_EN
        output round_ready,
`endif
        output busy, done, words
    );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, combinational.
// Ports: word (in, 32) -> subbed (out, 32).
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);

    assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]],
                     SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/key_expansion_seq.sv
// AES-128 key expansion, one word per cycle (w[4]..w[43] over 40 cycles).
// Ports: clk, rst_n (async, active-low), kif (slave). Option: KEYEXP_ROUND_READY_EN.
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_expansion_seq_if.slave   kif
);

    localparam logic [5:0] LAST_W = 6'(4 * (NR + 1) - 1);

    ks_state_t         state, nxt;
    logic              load, step, busy, done;
    logic [5:0]        idx;
    logic [7:0]        rcon;
    logic [0:32*NW-1]  words_q;

    logic [10:0]       wr_base, rd4_base, rd1_base;
    logic [31:0]       w4, w1, rot, sw, temp, nw;

    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                if (kif.start) begin
                    load = 1'b1;
                    nxt  = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx == LAST_W) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (kif.start) begin
                    load = 1'b1;
                    nxt  = EXPAND;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // w[i-4] and w[i-1] are read straight out of the result register
    assign wr_base  = {idx, 5'b0};
    assign rd4_base = wr_base - 11'd128;
    assign rd1_base = wr_base - 11'd32;
    assign w4       = words_q[rd4_base +: 32];
    assign w1       = words_q[rd1_base +: 32];
    assign rot      = {w1[23:0], w1[31:24]};

    aes_sub_word u_sub (
        .word   (rot),
        .subbed (sw)
    );

    assign temp = (idx[1:0] == 2'b00) ? (sw ^ {rcon, 24'h0}) : w1;
    assign nw   = w4 ^ temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
            idx     <= '0;
            rcon    <= '0;
        end else if (load) begin
            words_q[0:127] <= kif.key;
            idx            <= 6'd4;
            rcon           <= 8'h01;
        end else if (step) begin
            words_q[wr_base +: 32] <= nw;
            idx                    <= idx + 6'd1;
            if (idx[1:0] == 2'b00) rcon <= xtime(rcon);
        end
    end

`ifdef KEYEXP_ROUND_READY_EN
    logic [0:NR] rr;

    // round r completes with its last word, w[4r+3]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
        end else if (load) begin
            rr    <= '0;
            rr[0] <= 1'b1;
        end else if (step && idx[1:0] == 2'b11) begin
            rr[idx[5:2]] <= 1'b1;
        end
    end

    assign kif.round_ready = rr;
`endif

    assign kif.busy  = busy;
    assign kif.done  = done;
    assign kif.words = words_q;

endmodule

// File: doc/key_expansion_seq.md
KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 SHALL have parameter NR, default 10, meaning AES round count; only 10 (AES-128) is legal.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request expansion of key; sampled on a clk rising edge.
REQ-005 SHALL have port key  input  128 [0:127]  cipher key, MSB-first (byte 0 = key[0:7]); sampled with start.
REQ-006 SHALL have port busy  output  1  expansion in progress.
REQ-007 SHALL have port done  output  1  single-cycle pulse: all 44 words valid.
REQ-008 SHALL have port words  output  1408 [0:1407]  expanded key; word i = words[32*i +: 32], round key r = words[128*r +: 128], directly consumable by the cipher.

Function
REQ-009 SHALL implement states IDLE, EXPAND, DONE.
REQ-010 In IDLE or DONE, start=1 SHALL load key into words[0:127], set index i=4, set rcon=8'h01, go to EXPAND.
REQ-011 Each EXPAND cycle SHALL write exactly one word: w[i] = w[i-4] ^ temp; temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i%4==0, else w[i-1].
REQ-012 After each i%4==0 word, rcon SHALL advance by GF(2^8) xtime (01,02,04,08,10,20,40,80,1b,36).
REQ-013 Latency: start sampled at edge E0; w[i] written at edge E(i-3); w[43] at E40; 41 edges total.
REQ-014 busy SHALL be 1 from after E0 through E40; it SHALL be 0 in IDLE and DONE.
REQ-015 At E40 state SHALL go to DONE; done=1 for exactly the cycle after E40; DONE then goes to IDLE.
REQ-016 start while in EXPAND SHALL be ignored; the expansion in flight SHALL be unaffected.
REQ-017 start in the DONE cycle SHALL be accepted as in IDLE; done still pulses for that cycle.
REQ-018 words SHALL hold its value in IDLE/DONE until the next accepted start; words not yet written during EXPAND SHALL keep their previous value.
REQ-019 key changes outside an accepted start SHALL have no effect.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, words=0, i=0, rcon=0, including mid-expansion.
REQ-021 After rst_n release, the first accepted start SHALL behave per REQ-010..REQ-015.

Configuration
REQ-022 Macro KEYEXP_ROUND_READY_EN defined: SHALL add output round_ready [0:10], bit r set when words of round key r are all written (bit 0 at E0, bit r at edge E(4r)). The bitmask SHALL be cleared on accepted start (except bit 0) and on reset, and held after done. Without the macro: no such port, no logic.

Structure
REQ-023 Package aes_pkg SHALL hold NK=4, NW=44, NR=10, state encoding, rcon xtime constant 8'h1b, and S-box table.
REQ-024 SHALL instantiate one sub-module aes_sub_word (four parallel S-box lookups on 32 bits, combinational).
REQ-025 SHALL use a single datapath: one word computed per cycle.

Verification
REQ-026 FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6, done at cycle after E40, busy low with done.
REQ-027 Key 0 -> w[4]=62636363, round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 rst_n low at E20 mid-expansion -> words=0, busy=0, no done pulse, next start completes correctly.
REQ-029 start with a different key at E10 -> ignored, A.1 result unchanged; start held high in DONE -> second expansion starts, done pulses again 41 edges later.
REQ-030 With KEYEXP_ROUND_READY_EN -> round_ready = 11'b1 after E0, bit 1 at E4, bit 10 at E40, all bits set with done.
